// File: rtl/fma_write_buffer.sv
// Assembles lockstep FMA results into cache lines and queues them in a 2-entry FIFO for memory.
// Optional FMA_WRITE_BUFFER_STALL_EN adds a registered stall_out that is high while the FIFO is full.
module fma_write_buffer #(
   parameter int FMA_COUNT  = 2,
   parameter int WORD_WIDTH = 16,
   parameter int LINE_WIDTH = 3 * FMA_COUNT * WORD_WIDTH
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
   input  logic                            fma_valid_in,
   input  logic                            flush_in,
   input  logic                            line_ack_in,
   output logic [LINE_WIDTH-1:0]           line_out,
   output logic                            line_valid_out,
   output logic [1:0]                      slot_out,
`ifdef FMA_WRITE_BUFFER_STALL_EN
   output logic                            stall_out,
`endif
   output logic                            overflow_out
);

   localparam int CHUNK = FMA_COUNT * WORD_WIDTH;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [LINE_WIDTH-1:0]   asm_line;
   logic [LINE_WIDTH-1:0]   merged;
   logic [LINE_WIDTH-1:0]   fifo [2];
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic                    do_push;
   logic                    do_pop;
   logic                    push_accept;

   // Current assembly with this cycle's results dropped into the active slot.
   always_comb begin
      merged = asm_line;
      if (fma_valid_in) begin
         case (slot_out)
            2'd0:    merged[0 +: CHUNK]       = fma_c_in;
            2'd1:    merged[CHUNK +: CHUNK]   = fma_c_in;
            default: merged[2*CHUNK +: CHUNK] = fma_c_in;
         endcase
      end
   end

   // A full FIFO can still take a line when the head leaves in the same cycle.
   assign do_push     = (fma_valid_in && slot_out == 2'd2) ||
                        (flush_in && (slot_out != 2'd0 || fma_valid_in));
   assign do_pop      = line_ack_in && (state != EMPTY);
   assign push_accept = do_push && (state != FULL || do_pop);

   always_comb begin
      state_next = state;
      if (push_accept && !do_pop) begin
         state_next = (state == EMPTY) ? ONE : FULL;
      end else if (do_pop && !push_accept) begin
         state_next = (state == FULL) ? ONE : EMPTY;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= EMPTY;
         asm_line     <= '0;
         slot_out     <= 2'd0;
         overflow_out <= 1'b0;
         fifo[0]      <= '0;
         fifo[1]      <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
      end else begin
         state <= state_next;
         if (do_push) begin
            asm_line <= '0;
            slot_out <= 2'd0;
         end else if (fma_valid_in) begin
            asm_line <= merged;
            slot_out <= slot_out + 2'd1;
         end
         if (push_accept) begin
            fifo[wr_ptr] <= merged;
            wr_ptr       <= ~wr_ptr;
         end else if (do_push) begin
            overflow_out <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

`ifdef FMA_WRITE_BUFFER_STALL_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_out <= 1'b0;
      end else begin
         stall_out <= (state_next == FULL);
      end
   end
`endif

   assign line_out       = fifo[rd_ptr];
   assign line_valid_out = (state != EMPTY);

endmodule

// File: tb/tb_fma_write_buffer.sv
// Directed self-checking bench for fma_write_buffer: assembly, flush, FIFO order, overflow, async reset.
module tb_fma_write_buffer;

   logic        clk;
   logic        rstN;
   logic [31:0] fmaC;
   logic        fmaValid;
   logic        flush;
   logic        lineAck;
   logic [95:0] lineOut;
   logic        lineValid;
   logic [1:0]  slot;
   logic        overflow;
`ifdef FMA_WRITE_BUFFER_STALL_EN
   logic        stall;
`endif

   int vectors;
   int miscompares;

   fma_write_buffer dut (
      .clk_in         (clk),
      .rst_in         (rstN),
      .fma_c_in       (fmaC),
      .fma_valid_in   (fmaValid),
      .flush_in       (flush),
      .line_ack_in    (lineAck),
      .line_out       (lineOut),
      .line_valid_out (lineValid),
      .slot_out       (slot),
`ifdef FMA_WRITE_BUFFER_STALL_EN
      .stall_out      (stall),
`endif
      .overflow_out   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic fl, input logic ack);
      fmaValid = valid;
      fmaC     = data;
      flush    = fl;
      lineAck  = ack;
      @(posedge clk);
      #1;
      fmaValid = 1'b0;
      flush    = 1'b0;
      lineAck  = 1'b0;
   endtask

   task automatic fillLine(input logic [15:0] base, input logic ackLast);
      applyStimulus(1'b1, {base + 16'd2, base + 16'd1}, 1'b0, 1'b0);
      applyStimulus(1'b1, {base + 16'd4, base + 16'd3}, 1'b0, 1'b0);
      applyStimulus(1'b1, {base + 16'd6, base + 16'd5}, 1'b0, ackLast);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstN        = 1'b0;
      fmaC        = '0;
      fmaValid    = 1'b0;
      flush       = 1'b0;
      lineAck     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_line", lineOut, 96'h0);
      checkOutput("rst_valid", {95'h0, lineValid}, 96'h0);
      checkOutput("rst_slot", {94'h0, slot}, 96'h0);
      checkOutput("rst_ovf", {95'h0, overflow}, 96'h0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // Basic three-slot assembly.
      applyStimulus(1'b1, 32'h0002_0001, 1'b0, 1'b0);
      checkOutput("slot_1", {94'h0, slot}, 96'd1);
      checkOutput("no_valid_yet", {95'h0, lineValid}, 96'h0);
      applyStimulus(1'b1, 32'h0004_0003, 1'b0, 1'b0);
      checkOutput("slot_2", {94'h0, slot}, 96'd2);
      applyStimulus(1'b1, 32'h0006_0005, 1'b0, 1'b0);
      checkOutput("slot_0", {94'h0, slot}, 96'd0);
      checkOutput("line1_valid", {95'h0, lineValid}, 96'h1);
      checkOutput("line1_data", lineOut, 96'h0006_0005_0004_0003_0002_0001);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
         checkOutput("hold_data", lineOut, 96'h0006_0005_0004_0003_0002_0001);
         checkOutput("hold_valid", {95'h0, lineValid}, 96'h1);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("ack_pop", {95'h0, lineValid}, 96'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("ack_empty_valid", {95'h0, lineValid}, 96'h0);
      checkOutput("ack_empty_ovf", {95'h0, overflow}, 96'h0);

      // Partial line flush.
      applyStimulus(1'b1, 32'h0B0B_0A0A, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush_valid", {95'h0, lineValid}, 96'h1);
      checkOutput("flush_data", lineOut, 96'h0000_0000_0000_0000_0B0B_0A0A);
      checkOutput("flush_slot", {94'h0, slot}, 96'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("idle_flush_noop", {95'h0, lineValid}, 96'h0);

      // Flush merged with same-cycle valid data.
      applyStimulus(1'b1, 32'h2222_1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h4444_3333, 1'b1, 1'b0);
      checkOutput("flush_merge_data", lineOut, 96'h0000_0000_4444_3333_2222_1111);
      checkOutput("flush_merge_slot", {94'h0, slot}, 96'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

      // Overflow: third line dropped, first two retained in order.
      fillLine(16'h1000, 1'b0);
      fillLine(16'h2000, 1'b0);
      checkOutput("two_no_ovf", {95'h0, overflow}, 96'h0);
`ifdef FMA_WRITE_BUFFER_STALL_EN
      checkOutput("stall_full", {95'h0, stall}, 96'h1);
`endif
      fillLine(16'h3000, 1'b0);
      checkOutput("ovf_set", {95'h0, overflow}, 96'h1);
      checkOutput("ovf_head_a", lineOut, 96'h1006_1005_1004_1003_1002_1001);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("ovf_head_b", lineOut, 96'h2006_2005_2004_2003_2002_2001);
      checkOutput("ovf_b_valid", {95'h0, lineValid}, 96'h1);

      // Push and pop in the same cycle while full.
      fillLine(16'h4000, 1'b0);
      fillLine(16'h5000, 1'b1);
      checkOutput("pp_head_d", lineOut, 96'h4006_4005_4004_4003_4002_4001);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("pp_head_e", lineOut, 96'h5006_5005_5004_5003_5002_5001);
      checkOutput("pp_e_valid", {95'h0, lineValid}, 96'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("pp_drained", {95'h0, lineValid}, 96'h0);
      checkOutput("ovf_sticky", {95'h0, overflow}, 96'h1);

      // Async reset mid-assembly with two lines queued.
      fillLine(16'h6000, 1'b0);
      fillLine(16'h7000, 1'b0);
      applyStimulus(1'b1, 32'h0002_0001, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0004_0003, 1'b0, 1'b0);
      checkOutput("pre_rst_slot", {94'h0, slot}, 96'd2);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("arst_line", lineOut, 96'h0);
      checkOutput("arst_valid", {95'h0, lineValid}, 96'h0);
      checkOutput("arst_slot", {94'h0, slot}, 96'h0);
      checkOutput("arst_ovf", {95'h0, overflow}, 96'h0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      fillLine(16'h8000, 1'b0);
      checkOutput("fresh_data", lineOut, 96'h8006_8005_8004_8003_8002_8001);
      checkOutput("fresh_valid", {95'h0, lineValid}, 96'h1);
      checkOutput("fresh_ovf", {95'h0, overflow}, 96'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
